// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO-based ADC: datapath widths and the decimator FSM state type.
package vco_adc_pkg;

    localparam int PHASE_WIDTH = 11;
    localparam int OSR_LOG2    = 9;
    localparam int OUT_WIDTH   = PHASE_WIDTH + 2 * OSR_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        WARMUP = 2'd2,
        RUN    = 2'd3
    } vco_adc_state_t;

endpackage

// File: rtl/cic2_decimator.sv
// Second-order CIC (sinc^2) decimator by 2^OSR_LOG2 with modulo integrators and combs.
module cic2_decimator
    import vco_adc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   adv,
    input  logic [PHASE_WIDTH-1:0] d,
    output logic                   strobe,
    output logic [OUT_WIDTH-1:0]   c2
);

    logic [OUT_WIDTH-1:0] i1_q;
    logic [OUT_WIDTH-1:0] i2_q;
    logic [OUT_WIDTH-1:0] z1_q;
    logic [OUT_WIDTH-1:0] z2_q;
    logic [OUT_WIDTH-1:0] c1;
    logic [OSR_LOG2-1:0]  cnt_q;

    // Combs run on the pre-update integrator value; the result is only meaningful when strobe=1.
    assign strobe = adv && (cnt_q == '1);
    assign c1     = i2_q - z1_q;
    assign c2     = c1 - z2_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i1_q  <= '0;
            i2_q  <= '0;
            z1_q  <= '0;
            z2_q  <= '0;
            cnt_q <= '0;
        end else if (adv) begin
            i1_q  <= i1_q + OUT_WIDTH'(d);
            i2_q  <= i2_q + i1_q;
            cnt_q <= cnt_q + 1'b1;
            if (strobe) begin
                z1_q <= i2_q;
                z2_q <= c1;
            end
        end
    end

endmodule

// File: rtl/vco_phase_decimator.sv
// VCO-ADC back end: owns the VCO enable, differences the phase word, decimates it through
// a sinc^2 CIC and presents samples on a valid/ready output with a sticky overrun flag.
module vco_phase_decimator
    import vco_adc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   vco_enb,
    input  logic [PHASE_WIDTH-1:0] p,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overrun
);

    vco_adc_state_t state_q, state_d;
    logic                   warm_q, warm_d;
    logic [PHASE_WIDTH-1:0] p_prev;
    logic [PHASE_WIDTH-1:0] d;
    logic                   clr;
    logic                   adv;
    logic                   strobe;
    logic [OUT_WIDTH-1:0]   c2;
    logic                   new_sample;

    assign clr        = !en && (state_q != IDLE);
    assign adv        = en && ((state_q == WARMUP) || (state_q == RUN));
    assign new_sample = strobe && (state_q == RUN);
    // Modulo subtraction absorbs the phase wrap of the VCO counter.
    assign d          = p - p_prev;

    // FSM: warm_q remembers that the first comb-fill strobe has already been discarded.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = PRIME;
            end
            PRIME: begin
                state_d = WARMUP;
                warm_d  = 1'b0;
            end
            WARMUP: begin
                if (strobe) begin
                    warm_d = 1'b1;
                    if (warm_q) state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            warm_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            warm_q  <= 1'b0;
            vco_enb <= 1'b1;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            vco_enb <= (state_d == IDLE);
        end
    end

    // Phase differencer: p_prev is loaded in PRIME and every active clk after it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            p_prev <= '0;
        end else if (en && (state_q != IDLE)) begin
            p_prev <= p;
        end
    end

    cic2_decimator u_cic (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .adv    (adv),
        .d      (d),
        .strobe (strobe),
        .c2     (c2)
    );

    // Output holding register: a new sample only lands when the slot is empty or being drained.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (new_sample && (!dout_valid || dout_ready)) begin
            dout       <= c2;
            dout_valid <= 1'b1;
        end else begin
            if (dout_valid && dout_ready) dout_valid <= 1'b0;
            if (new_sample)               overrun    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vco_phase_decimator.sv
// Scoreboard bench for vco_phase_decimator against a triangle-weighted sinc^2 reference model.
module tb_vco_phase_decimator;
    import vco_adc_pkg::*;

    localparam int OSR     = 1 << OSR_LOG2;
    localparam int PH_MOD  = 1 << PHASE_WIDTH;
    localparam int FIRST_T = 3 * OSR + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic                   vco_enb;
    logic [PHASE_WIDTH-1:0] p;
    logic [OUT_WIDTH-1:0]   dout;
    logic                   dout_valid;
    logic                   dout_ready;
    logic                   overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state: t_m counts edges since the enabling edge (-1 while idle).
    int                   t_m = -1;
    int                   phase_hist[$];
    bit                   occ_m = 1'b0;
    bit                   ovr_m = 1'b0;
    logic [OUT_WIDTH-1:0] exp_q[$];

    always #10 clk = ~clk;

    vco_phase_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .vco_enb    (vco_enb),
        .p          (p),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t_m);
        end
    endtask

    // Sample n of a sinc^2 decimator: triangle of length 2*OSR-1 over the phase increments.
    function automatic logic [OUT_WIDTH-1:0] ref_sample(input int n);
        longint acc;
        int     j;
        longint dj;
        longint w;
        acc = 0;
        for (int tt = 1; tt < 2 * OSR; tt++) begin
            j   = n * OSR - 1 - tt;
            dj  = longint'((phase_hist[j] - phase_hist[j-1]) & (PH_MOD - 1));
            w   = (tt <= OSR) ? longint'(tt) : longint'(2 * OSR - tt);
            acc += w * dj;
        end
        return OUT_WIDTH'(acc);
    endfunction

    // One clock: drive inputs, advance the model for the coming edge, then check control outputs.
    task automatic cycle(input bit en_i, input logic [PHASE_WIDTH-1:0] p_i, input bit rdy_i);
        bit xfer;
        bit fresh;
        en         = en_i;
        p          = p_i;
        dout_ready = rdy_i;
        xfer       = occ_m && rdy_i;
        if (t_m < 0) begin
            if (en_i) begin
                t_m = 0;
                phase_hist.delete();
            end
        end else if (!en_i) begin
            if (occ_m && !rdy_i && exp_q.size() > 0) void'(exp_q.pop_front());
            t_m   = -1;
            occ_m = 1'b0;
            ovr_m = 1'b0;
        end else begin
            t_m++;
            phase_hist.push_back(int'(p_i));
            fresh = ((t_m - 1) % OSR == 0) && ((t_m - 1) / OSR >= 3);
            if (fresh) begin
                if (occ_m && !rdy_i) begin
                    ovr_m = 1'b1;
                end else begin
                    occ_m = 1'b1;
                    exp_q.push_back(ref_sample((t_m - 1) / OSR));
                end
            end else if (xfer) begin
                occ_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ctrl{vco_enb,valid,overrun}", 64'({vco_enb, dout_valid, overrun}),
            64'({t_m < 0, occ_m, ovr_m}));
    endtask

    task automatic go_idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, PHASE_WIDTH'($urandom), 1'($urandom));
    endtask

    // Runs a constant-increment conversion and returns the t at which dout_valid first rose.
    task automatic run_const(input int inc, input int ncyc, output int first_t,
                             output logic [OUT_WIDTH-1:0] first_val);
        logic [PHASE_WIDTH-1:0] ph;
        ph        = PHASE_WIDTH'($urandom);
        first_t   = -1;
        first_val = '0;
        for (int k = 0; k < ncyc; k++) begin
            cycle(1'b1, ph, 1'b1);
            ph = ph + PHASE_WIDTH'(inc);
            if (dout_valid && first_t < 0) begin
                first_t   = t_m;
                first_val = dout;
            end
        end
    endtask

    // Monitor: pops one expected sample per observed transfer.
    initial begin
        logic [OUT_WIDTH-1:0] exp;
        forever begin
            @(negedge clk);
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: got dout=%0d, expected no transfer", dout);
                end else begin
                    exp = exp_q.pop_front();
                    if (dout !== exp) begin
                        errors++;
                        $display("FAIL xfer_data: got %0d, expected %0d", dout, exp);
                    end
                end
            end
        end
    end

    initial begin
        int                     ft;
        logic [OUT_WIDTH-1:0]   fv;
        logic [PHASE_WIDTH-1:0] ph;
        int                     inc;
        bit                     rdy;

        rst        = 1'b1;
        en         = 1'b0;
        p          = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ctrl", 64'({vco_enb, dout_valid, overrun}), 64'(3'b100));
        chk("reset_dout", 64'(dout), 64'd0);

        // Idle with en low: VCO held off, nothing produced.
        for (int k = 0; k < 100; k++) begin
            cycle(1'b0, PHASE_WIDTH'($urandom), 1'($urandom));
            chk("idle_dout", 64'(dout), 64'd0);
        end

        // Constant increment of 5: latency 3*OSR+2 clks, value 5*OSR^2.
        run_const(5, 7 * OSR + 2, ft, fv);
        chk("first_latency_t", 64'(ft), 64'(FIRST_T));
        chk("first_value", 64'(fv), 64'd1310720);
        go_idle(3);

        // Increments alternating 2047 and 1: wraps every clk.
        ph = PHASE_WIDTH'($urandom);
        for (int k = 0; k < 6 * OSR + 2; k++) begin
            cycle(1'b1, ph, 1'b1);
            ph = ph + ((k % 2 == 0) ? PHASE_WIDTH'(2047) : PHASE_WIDTH'(1));
            if (dout_valid) chk("wrap_value", 64'(dout), 64'd268435456);
        end
        go_idle(3);

        // Ready held low across two strobes: first held, second dropped.
        ph = '0;
        for (int k = 0; k <= 4 * OSR + 4; k++) begin
            cycle(1'b1, ph, 1'b0);
            ph = ph + PHASE_WIDTH'(5);
        end
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_held_value", 64'(dout), 64'd1310720);
        cycle(1'b1, ph, 1'b1);
        ph = ph + PHASE_WIDTH'(5);
        chk("ovr_after_xfer_valid", 64'(dout_valid), 64'd0);
        chk("ovr_sticky", 64'(overrun), 64'd1);
        for (int k = 0; k < OSR; k++) begin
            cycle(1'b1, ph, 1'b1);
            ph = ph + PHASE_WIDTH'(5);
        end
        chk("ovr_still_sticky", 64'(overrun), 64'd1);
        go_idle(1);
        chk("ovr_cleared_by_en", 64'(overrun), 64'd0);
        go_idle(2);

        // Ready raised exactly on the strobe clk: back-to-back transfer, no overrun.
        inc = int'($urandom_range(0, PH_MOD - 1));
        ph  = PHASE_WIDTH'($urandom);
        for (int k = 0; k <= 5 * OSR + 4; k++) begin
            rdy = (k == 4 * OSR + 1) || (k > 4 * OSR + 8);
            cycle(1'b1, ph, rdy);
            ph = ph + PHASE_WIDTH'(inc);
            if (k == 4 * OSR + 1) chk("b2b_valid_kept", 64'(dout_valid), 64'd1);
        end
        chk("b2b_no_overrun", 64'(overrun), 64'd0);
        go_idle(2);

        // Stop mid-decimation, then restart: timing identical to a fresh start.
        run_const(5, 4 * OSR, ft, fv);
        cycle(1'b0, ph, 1'b1);
        chk("stop_vco_enb", 64'(vco_enb), 64'd1);
        go_idle(2);
        run_const(5, 4 * OSR, ft, fv);
        chk("restart_latency_t", 64'(ft), 64'(FIRST_T));
        chk("restart_value", 64'(fv), 64'd1310720);
        go_idle(2);

        // Random phase and random back-pressure.
        ph = PHASE_WIDTH'($urandom);
        for (int k = 0; k < 8 * OSR; k++) begin
            cycle(1'b1, ph, ($urandom_range(0, 9) < 7));
            ph = PHASE_WIDTH'($urandom);
        end
        go_idle(4);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
